// File: rtl/osd_regaccess_out_arbiter_if.sv
// Flit bundle between the packet sources and the shared DII output link.
// The master view belongs to the arbiter, the slave view to whatever surrounds it.
interface osd_regaccess_out_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [16*NUM_PORTS-1:0] in_data;
  logic [NUM_PORTS-1:0]    in_last;
  logic [NUM_PORTS-1:0]    in_valid;
  logic [NUM_PORTS-1:0]    in_ready;
  logic [15:0]             out_data;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

  modport slave (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/osd_regaccess_out_arbiter.sv
// Packet-granular arbiter sharing one DII output link between NUM_PORTS sources,
// with overlong-packet truncation and a single registered output stage.
module osd_regaccess_out_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int MAX_PKT_LEN = 12,
  parameter int PRIO_PORT0  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  osd_regaccess_out_arbiter_if.master bus,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        err_overlong,
  input  logic                        err_clr
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        ptr, ptr_nxt, owner, owner_nxt, win, sel, cand;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [NUM_PORTS-1:0] grant_nxt, rdy;
  logic                 win_vld, ld, acc, flit_last, force_last, err_set;
  logic [15:0]          flit_data;
  logic [15:0]          data_p1;
  logic                 last_p1, vld_p1;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign ld = !vld_p1 | bus.out_ready;

  // stage p0: arbitration, flit selection and handshake
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    cand    = '0;
    if (PRIO_PORT0 != 0 && bus.in_valid[0]) begin
      win     = '0;
      win_vld = 1'b1;
    end
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_PORTS);
      if (!win_vld && bus.in_valid[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign sel = (state == IDLE) ? win : owner;

  always_comb begin
    flit_data = '0;
    flit_last = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PW'(i) == sel) begin
        flit_data = bus.in_data[16*i +: 16];
        flit_last = bus.in_last[i];
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (rst) begin
      case (state)
        IDLE:    if (win_vld) rdy[win] = ld;
        PKT:     rdy = grant & {NUM_PORTS{ld}};
        DROP:    rdy[owner] = 1'b1;
        default: rdy = '0;
      endcase
    end
  end

  assign bus.in_ready = rdy;
  assign acc          = rdy[sel] & bus.in_valid[sel];

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    grant_nxt  = grant;
    force_last = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          cnt_nxt   = CW'(1);
          owner_nxt = win;
          if (flit_last) begin
            ptr_nxt = win;
          end else begin
            state_nxt = PKT;
            grant_nxt = onehot(win);
          end
        end
      end
      PKT: begin
        if (acc) begin
          cnt_nxt = cnt + CW'(1);
          if (flit_last) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = owner;
          end else if (cnt + CW'(1) == CW'(MAX_PKT_LEN)) begin
            // truncate: close the packet downstream and swallow the rest
            force_last = 1'b1;
            err_set    = 1'b1;
            state_nxt  = DROP;
          end
        end
      end
      DROP: begin
        if (acc && flit_last) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= PW'(NUM_PORTS - 1);
      owner        <= '0;
      cnt          <= '0;
      grant        <= '0;
      err_overlong <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      grant <= grant_nxt;
      if (err_set)      err_overlong <= 1'b1;
      else if (err_clr) err_overlong <= 1'b0;
    end
  end

  // stage p1: registered output flit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (ld) begin
      vld_p1 <= acc && (state != DROP);
      if (acc && (state != DROP)) begin
        data_p1 <= flit_data;
        last_p1 <= flit_last | force_last;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_last  = last_p1;
endmodule

// File: tb/tb_osd_regaccess_out_arbiter.sv
// Bench for the output arbiter: a round-robin and a port-0-priority instance share
// one directed stimulus script and are checked each cycle against a packet-level model.
module tb_osd_regaccess_out_arbiter;
  localparam int NP  = 2;
  localparam int MPL = 4;

  typedef struct packed { logic v; logic [15:0] d; logic l; } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [16*NP-1:0] drv_d [2];
  logic [NP-1:0]    drv_v [2];
  logic [NP-1:0]    drv_l [2];
  logic             drv_ordy, drv_clr;
  logic [NP-1:0]    q_rdy [2];
  logic [NP-1:0]    q_gnt [2];
  logic [15:0]      q_d [2];
  logic             q_v [2];
  logic             q_l [2];
  logic             q_err [2];
  logic [NP-1:0]    gnt_a, gnt_b;
  logic             err_a, err_b;

  osd_regaccess_out_arbiter_if #(.NUM_PORTS(NP)) ifa ();
  osd_regaccess_out_arbiter_if #(.NUM_PORTS(NP)) ifb ();

  osd_regaccess_out_arbiter #(.NUM_PORTS(NP), .MAX_PKT_LEN(MPL), .PRIO_PORT0(0)) dut_rr (
    .clk(clk), .rst(rst), .bus(ifa), .grant(gnt_a), .err_overlong(err_a), .err_clr(drv_clr));
  osd_regaccess_out_arbiter #(.NUM_PORTS(NP), .MAX_PKT_LEN(MPL), .PRIO_PORT0(1)) dut_pr (
    .clk(clk), .rst(rst), .bus(ifb), .grant(gnt_b), .err_overlong(err_b), .err_clr(drv_clr));

  assign ifa.in_data = drv_d[0];  assign ifb.in_data = drv_d[1];
  assign ifa.in_valid = drv_v[0]; assign ifb.in_valid = drv_v[1];
  assign ifa.in_last = drv_l[0];  assign ifb.in_last = drv_l[1];
  assign ifa.out_ready = drv_ordy; assign ifb.out_ready = drv_ordy;
  assign q_rdy[0] = ifa.in_ready;  assign q_rdy[1] = ifb.in_ready;
  assign q_d[0] = ifa.out_data;    assign q_d[1] = ifb.out_data;
  assign q_v[0] = ifa.out_valid;   assign q_v[1] = ifb.out_valid;
  assign q_l[0] = ifa.out_last;    assign q_l[1] = ifb.out_last;
  assign q_gnt[0] = gnt_a;         assign q_gnt[1] = gnt_b;
  assign q_err[0] = err_a;         assign q_err[1] = err_b;

  // packet-level model: who owns the link, whether the rest is being dropped,
  // flits so far, last winner, the one output register and the sticky error
  ent_t        srcq [2][NP][$];
  ent_t        logq [2][$];
  int          m_owner [2];
  bit          m_drop [2];
  int          m_n [2];
  int          m_lastw [2];
  bit          m_ov [2];
  logic [15:0] m_od [2];
  bit          m_ol [2];
  bit          m_err [2];
  bit          m_prio [2];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] ex[$];

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_drop[k] = 1'b0; m_n[k] = 0; m_lastw[k] = NP - 1;
      m_ov[k] = 1'b0; m_od[k] = '0; m_ol[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  function automatic logic [NP-1:0] m_ready(input int k);
    logic [NP-1:0] r;
    bit ld;
    int w;
    r = '0;
    w = -1;
    if (!rst) return r;
    ld = !m_ov[k] || drv_ordy;
    if (m_owner[k] < 0) begin
      if (m_prio[k] && drv_v[k][0]) w = 0;
      for (int i = 1; i <= NP; i++)
        if (w < 0 && drv_v[k][(m_lastw[k] + i) % NP]) w = (m_lastw[k] + i) % NP;
      if (w >= 0) r[w] = ld;
    end else if (m_drop[k]) begin
      r[m_owner[k]] = 1'b1;
    end else begin
      r[m_owner[k]] = ld;
    end
    return r;
  endfunction

  function automatic logic [NP-1:0] m_grant(input int k);
    logic [NP-1:0] g;
    g = '0;
    if (m_owner[k] >= 0) g[m_owner[k]] = 1'b1;
    return g;
  endfunction

  task automatic m_step(input int k);
    logic [NP-1:0] r;
    int   a;
    bit   ld, take, fl, set;
    ent_t f;
    a = -1; take = 1'b0; fl = 1'b0; set = 1'b0; f = '0;
    if (!rst) return;
    r  = m_ready(k);
    ld = !m_ov[k] || drv_ordy;
    for (int p = 0; p < NP; p++) if (r[p] && drv_v[k][p]) a = p;
    if (a >= 0) begin
      f  = srcq[k][a].pop_front();
      fl = f.l;
      if (m_owner[k] < 0) begin
        m_n[k] = 1; take = 1'b1;
        if (f.l) m_lastw[k] = a;
        else begin m_owner[k] = a; m_drop[k] = 1'b0; end
      end else if (m_drop[k]) begin
        if (f.l) begin m_owner[k] = -1; m_drop[k] = 1'b0; m_lastw[k] = a; end
      end else begin
        m_n[k]++; take = 1'b1;
        if (f.l) begin m_owner[k] = -1; m_lastw[k] = a; end
        else if (m_n[k] == MPL) begin fl = 1'b1; set = 1'b1; m_drop[k] = 1'b1; end
      end
    end
    for (int p = 0; p < NP; p++)
      if (p != a && srcq[k][p].size() > 0 && !srcq[k][p][0].v) void'(srcq[k][p].pop_front());
    if (ld) begin
      m_ov[k] = take;
      if (take) begin
        m_od[k] = f.d; m_ol[k] = fl;
        logq[k].push_back({1'b1, f.d, fl});
      end
    end
    if (set) m_err[k] = 1'b1;
    else if (drv_clr) m_err[k] = 1'b0;
  endtask

  task automatic step(input bit ordy, input bit clr);
    ent_t e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("out_valid", k, 32'(q_v[k]), 32'(m_ov[k]));
      chk("out_data", k, 32'(q_d[k]), 32'(m_od[k]));
      chk("out_last", k, 32'(q_l[k]), 32'(m_ol[k]));
      chk("grant", k, 32'(q_gnt[k]), 32'(m_grant(k)));
      chk("err_overlong", k, 32'(q_err[k]), 32'(m_err[k]));
    end
    drv_ordy = ordy;
    drv_clr  = clr;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) begin
        e = (srcq[k][p].size() > 0) ? srcq[k][p][0] : '0;
        drv_v[k][p] = e.v; drv_l[k][p] = e.l; drv_d[k][16*p +: 16] = e.d;
      end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("in_ready", k, 32'(q_rdy[k]), 32'(m_ready(k)));
      m_step(k);
    end
  endtask

  function automatic bit busy();
    bit b;
    b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (m_ov[k]) b = 1'b1;
      for (int p = 0; p < NP; p++) if (srcq[k][p].size() > 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic run(input logic [15:0] pat, input bit clr);
    int c;
    c = 0;
    while (busy() && c < 200) begin
      step(pat[c % 16], clr);
      c++;
    end
    chk("drain", 0, 32'(busy()), 32'(0));
    step(1'b1, clr);
  endtask

  task automatic push(input int p, input logic [15:0] d, input bit l);
    for (int k = 0; k < 2; k++) srcq[k][p].push_back({1'b1, d, l});
  endtask

  task automatic bubble(input int p);
    for (int k = 0; k < 2; k++) srcq[k][p].push_back({1'b0, 16'h0000, 1'b0});
  endtask

  task automatic chk_log(input string nm, input int k, input logic [15:0] ed[$], input logic [15:0] mask);
    chk({nm, "_len"}, k, 32'(logq[k].size()), 32'(ed.size()));
    for (int i = 0; i < ed.size() && i < logq[k].size(); i++) begin
      chk({nm, "_data"}, k, 32'(logq[k][i].d), 32'(ed[i]));
      chk({nm, "_last"}, k, 32'(logq[k][i].l), 32'(mask[i]));
    end
    logq[k].delete();
  endtask

  initial begin
    m_prio[0] = 1'b0;
    m_prio[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin drv_d[k] = '0; drv_v[k] = '0; drv_l[k] = '0; end
    drv_ordy = 1'b1;
    drv_clr  = 1'b0;
    m_reset();

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 32'(q_v[k]), 32'(0));
      chk("rst_out_data", k, 32'(q_d[k]), 32'(0));
      chk("rst_grant", k, 32'(q_gnt[k]), 32'(0));
      chk("rst_err", k, 32'(q_err[k]), 32'(0));
      chk("rst_in_ready", k, 32'(q_rdy[k]), 32'(0));
    end
    rst = 1'b1;

    // single 3-flit packet on port 0
    push(0, 16'h0001, 1'b0); push(0, 16'h0002, 1'b0); push(0, 16'h8003, 1'b1);
    run(16'hFFFF, 1'b0);
    ex = '{16'h0001, 16'h0002, 16'h8003};
    for (int k = 0; k < 2; k++) begin
      chk_log("single", k, ex, 16'h0004);
      chk("single_grant_after", k, 32'(q_gnt[k]), 32'(0));
    end

    // three 2-flit packets queued on each port
    for (int j = 0; j < 3; j++)
      for (int p = 0; p < NP; p++)
        for (int f = 0; f < 2; f++)
          push(p, 16'h0A00 | 16'(p << 8) | 16'(j << 4) | 16'(f), f == 1);
    run(16'hFFFF, 1'b0);
    ex = '{16'h0B00, 16'h0B01, 16'h0A00, 16'h0A01, 16'h0B10, 16'h0B11,
           16'h0A10, 16'h0A11, 16'h0B20, 16'h0B21, 16'h0A20, 16'h0A21};
    chk_log("round_robin", 0, ex, 16'h0AAA);
    ex = '{16'h0A00, 16'h0A01, 16'h0A10, 16'h0A11, 16'h0A20, 16'h0A21,
           16'h0B00, 16'h0B01, 16'h0B10, 16'h0B11, 16'h0B20, 16'h0B21};
    chk_log("priority", 1, ex, 16'h0AAA);

    // exactly MAX_PKT_LEN flits under backpressure: legal, no error
    push(1, 16'h2001, 1'b0); push(1, 16'h2002, 1'b0); push(1, 16'h2003, 1'b0); push(1, 16'h2004, 1'b1);
    run(16'hFFF3, 1'b0);
    ex = '{16'h2001, 16'h2002, 16'h2003, 16'h2004};
    for (int k = 0; k < 2; k++) begin
      chk_log("backpressure", k, ex, 16'h0008);
      chk("maxlen_no_err", k, 32'(q_err[k]), 32'(0));
    end

    // valid gap inside a packet, competing single-flit packet waits
    push(0, 16'h0101, 1'b0); bubble(0); push(0, 16'h0102, 1'b0); push(0, 16'h0103, 1'b1);
    push(1, 16'h3001, 1'b1);
    run(16'hFFFF, 1'b0);
    ex = '{16'h0101, 16'h0102, 16'h0103, 16'h3001};
    for (int k = 0; k < 2; k++) chk_log("gap", k, ex, 16'h000C);

    // overlong packet, then clear
    for (int i = 1; i <= 6; i++) push(1, 16'h4000 | 16'(i), i == 6);
    run(16'hFFFF, 1'b0);
    ex = '{16'h4001, 16'h4002, 16'h4003, 16'h4004};
    for (int k = 0; k < 2; k++) begin
      chk_log("overlong", k, ex, 16'h0008);
      chk("overlong_err_set", k, 32'(q_err[k]), 32'(1));
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) chk("overlong_err_clr", k, 32'(q_err[k]), 32'(0));

    // overlong with err_clr held high and irregular backpressure
    for (int i = 1; i <= 6; i++) push(0, 16'h5000 | 16'(i), i == 6);
    run(16'hB6DB, 1'b1);
    ex = '{16'h5001, 16'h5002, 16'h5003, 16'h5004};
    for (int k = 0; k < 2; k++) begin
      chk_log("overlong_clr", k, ex, 16'h0008);
      chk("overlong_clr_err", k, 32'(q_err[k]), 32'(0));
    end

    // asynchronous reset during the second flit
    push(0, 16'h6001, 1'b0); push(0, 16'h6002, 1'b0); push(0, 16'h6003, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_rst_out_valid", k, 32'(q_v[k]), 32'(0));
      chk("async_rst_grant", k, 32'(q_gnt[k]), 32'(0));
      chk("async_rst_in_ready", k, 32'(q_rdy[k]), 32'(0));
      for (int p = 0; p < NP; p++) srcq[k][p].delete();
      logq[k].delete();
      drv_v[k] = '0;
    end
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    push(0, 16'h7001, 1'b1);
    push(1, 16'h7101, 1'b1);
    run(16'hFFFF, 1'b0);
    ex = '{16'h7001, 16'h7101};
    for (int k = 0; k < 2; k++) chk_log("post_reset", k, ex, 16'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
